// File: rtl/mips_ex_pkg.sv
// Shared constants for the MIPS execute stage: ALUop classes, R-type Func
// codes and the 3-bit ALU operation encoding.
package mips_ex_pkg;

  localparam logic [4:0] ALUOP_RTYPE = 5'd0;
  localparam logic [4:0] ALUOP_ADDI  = 5'd1;
  localparam logic [4:0] ALUOP_ANDI  = 5'd2;
  localparam logic [4:0] ALUOP_ORI   = 5'd3;
  localparam logic [4:0] ALUOP_XORI  = 5'd4;
  localparam logic [4:0] ALUOP_SLTI  = 5'd5;
  localparam logic [4:0] ALUOP_LUI   = 5'd6;
  localparam logic [4:0] ALUOP_LDST  = 5'd7;
  localparam logic [4:0] ALUOP_HALT  = 5'h1F;

  localparam logic [5:0] FUNC_SLL   = 6'h00;
  localparam logic [5:0] FUNC_SRL   = 6'h02;
  localparam logic [5:0] FUNC_SRA   = 6'h03;
  localparam logic [5:0] FUNC_SLLV  = 6'h04;
  localparam logic [5:0] FUNC_SRLV  = 6'h06;
  localparam logic [5:0] FUNC_SRAV  = 6'h07;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;
  localparam logic [5:0] FUNC_ADD   = 6'h20;
  localparam logic [5:0] FUNC_ADDU  = 6'h21;
  localparam logic [5:0] FUNC_SUB   = 6'h22;
  localparam logic [5:0] FUNC_SUBU  = 6'h23;
  localparam logic [5:0] FUNC_AND   = 6'h24;
  localparam logic [5:0] FUNC_OR    = 6'h25;
  localparam logic [5:0] FUNC_XOR   = 6'h26;
  localparam logic [5:0] FUNC_NOR   = 6'h27;
  localparam logic [5:0] FUNC_SLT   = 6'h2A;
  localparam logic [5:0] FUNC_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOR   = 3'b101,
    ALU_SLT   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_ctrl_e;

  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
           (func == FUNC_DIV)  || (func == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/mips_ex_alu_unit_core.sv
// 32-bit integer ALU with Zero and signed-Positive result flags.
module ex_alu_core
  import mips_ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic        [2:0]       i_ctrl,
  output logic        [WIDTH-1:0] o_result,
  output logic                    o_zero,
  output logic                    o_positive
);

  logic [WIDTH-1:0] w_result;

  function automatic logic [WIDTH-1:0] slt_signed(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r    = '0;
    r[0] = (a < b);
    return r;
  endfunction

  always_comb begin
    w_result = '0;
    case (alu_ctrl_e'(i_ctrl))
      ALU_ADD:   w_result = i_a + i_b;
      ALU_SUB:   w_result = i_a - i_b;
      ALU_AND:   w_result = i_a & i_b;
      ALU_OR:    w_result = i_a | i_b;
      ALU_XOR:   w_result = i_a ^ i_b;
      ALU_NOR:   w_result = ~(i_a | i_b);
      ALU_SLT:   w_result = slt_signed(i_a, i_b);
      ALU_PASSB: w_result = i_b;
      default:   w_result = i_a + i_b;
    endcase
  end

  assign o_result   = w_result;
  assign o_zero     = (w_result == '0);
  assign o_positive = ~w_result[WIDTH-1] & (w_result != '0);

endmodule

// File: rtl/mips_ex_alu_unit_decode.sv
// ALU-control decode (combinational) and the sticky Halt flag register.
module ex_alu_decode
  import mips_ex_pkg::*;
#(
  parameter logic [4:0] HALT_OP = ALUOP_HALT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_aluop,
  input  logic [5:0] i_func,
  input  logic       i_branch,
  input  logic       i_alu_busy,
  output logic [2:0] o_alu_ctrl,
  output logic       o_front_sel,
  output logic       o_multi_clk,
  output logic       o_halt
);

  alu_ctrl_e w_ctrl;
  alu_ctrl_e w_rtype_ctrl;
  logic      w_muldiv;
  logic      r_halt;

  always_comb begin
    w_rtype_ctrl = ALU_ADD;
    case (i_func)
      FUNC_ADD, FUNC_ADDU: w_rtype_ctrl = ALU_ADD;
      FUNC_SUB, FUNC_SUBU: w_rtype_ctrl = ALU_SUB;
      FUNC_AND:            w_rtype_ctrl = ALU_AND;
      FUNC_OR:             w_rtype_ctrl = ALU_OR;
      FUNC_XOR:            w_rtype_ctrl = ALU_XOR;
      FUNC_NOR:            w_rtype_ctrl = ALU_NOR;
      FUNC_SLT, FUNC_SLTU: w_rtype_ctrl = ALU_SLT;
      // shifts, mfhi/mflo and mult/div arrive pre-computed on operand A
      default:             w_rtype_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    w_ctrl   = ALU_ADD;
    w_muldiv = (i_aluop == ALUOP_RTYPE) && is_muldiv(i_func);
    if (i_branch) begin
      w_ctrl = ALU_SUB;
    end else begin
      case (i_aluop)
        ALUOP_RTYPE: w_ctrl = w_rtype_ctrl;
        ALUOP_ADDI:  w_ctrl = ALU_ADD;
        ALUOP_ANDI:  w_ctrl = ALU_AND;
        ALUOP_ORI:   w_ctrl = ALU_OR;
        ALUOP_XORI:  w_ctrl = ALU_XOR;
        ALUOP_SLTI:  w_ctrl = ALU_SLT;
        ALUOP_LUI:   w_ctrl = ALU_PASSB;
        ALUOP_LDST:  w_ctrl = ALU_ADD;
        default:     w_ctrl = ALU_ADD;
      endcase
    end
  end

  // Halt is sticky until reset; reset wins over a simultaneous halt op
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_halt <= 1'b0;
    end else if (i_aluop == HALT_OP) begin
      r_halt <= 1'b1;
    end
  end

  assign o_alu_ctrl  = w_ctrl;
  assign o_front_sel = ~w_muldiv;
  assign o_multi_clk = w_muldiv & i_alu_busy;
  assign o_halt      = r_halt;

endmodule

// File: rtl/mips_ex_alu_unit.sv
// Execute-stage arithmetic: ALU-control decode, integer ALU and the
// standalone PC/branch-target adder.
module mips_ex_alu_unit
  import mips_ex_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] HALT_OP = ALUOP_HALT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ALUop,
  input  logic [5:0]       Func,
  input  logic             Branch,
  input  logic             ALUBusy,
  input  logic [WIDTH-1:0] AluIn1,
  input  logic [WIDTH-1:0] AluIn2,
  input  logic [WIDTH-1:0] AddA,
  input  logic [WIDTH-1:0] AddB,
  output logic [WIDTH-1:0] AddSum,
  output logic [2:0]       AluControl,
  output logic             AluFrontSel,
  output logic             MultiClk,
  output logic [WIDTH-1:0] AluResult,
  output logic             Zero,
  output logic             Positive,
  output logic             Halt
);

  logic [2:0] w_alu_ctrl;

  ex_alu_decode #(
    .HALT_OP (HALT_OP)
  ) u_decode (
    .i_clk       (Clk),
    .i_rst       (Rst),
    .i_aluop     (ALUop),
    .i_func      (Func),
    .i_branch    (Branch),
    .i_alu_busy  (ALUBusy),
    .o_alu_ctrl  (w_alu_ctrl),
    .o_front_sel (AluFrontSel),
    .o_multi_clk (MultiClk),
    .o_halt      (Halt)
  );

  ex_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a        (AluIn1),
    .i_b        (AluIn2),
    .i_ctrl     (w_alu_ctrl),
    .o_result   (AluResult),
    .o_zero     (Zero),
    .o_positive (Positive)
  );

  assign AluControl = w_alu_ctrl;
  assign AddSum     = AddA + AddB;

endmodule

// File: tb/tb_mips_ex_alu_unit.sv
// Directed bench for mips_ex_alu_unit: Halt register, decode, ALU and adder.
module tb_mips_ex_alu_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ALUop;
  logic [5:0]  Func;
  logic        Branch;
  logic        ALUBusy;
  logic [31:0] AluIn1, AluIn2, AddA, AddB;
  logic [31:0] AddSum, AluResult;
  logic [2:0]  AluControl;
  logic        AluFrontSel, MultiClk, Zero, Positive, Halt;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mips_ex_alu_unit #(.WIDTH(32), .HALT_OP(5'h1F)) dut (
    .Clk(Clk), .Rst(Rst), .ALUop(ALUop), .Func(Func), .Branch(Branch),
    .ALUBusy(ALUBusy), .AluIn1(AluIn1), .AluIn2(AluIn2), .AddA(AddA),
    .AddB(AddB), .AddSum(AddSum), .AluControl(AluControl),
    .AluFrontSel(AluFrontSel), .MultiClk(MultiClk), .AluResult(AluResult),
    .Zero(Zero), .Positive(Positive), .Halt(Halt)
  );

  task automatic set_op(input logic [4:0] op, input logic [5:0] fn, input logic br,
                        input logic [31:0] a, input logic [31:0] b);
    ALUop = op; Func = fn; Branch = br; AluIn1 = a; AluIn2 = b;
    #1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1; ALUop = 5'd0;
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (Halt !== 1'b0) begin
      failures++; $display("FAIL reset_halt got=%b exp=0", Halt);
    end
  endtask

  task automatic test_halt();
    @(negedge Clk);
    ALUop = 5'h1F;
    #1;
    checks++;
    if (Halt !== 1'b0) begin
      failures++; $display("FAIL halt_latency got=%b exp=0", Halt);
    end
    @(posedge Clk); #1;
    checks++;
    if (Halt !== 1'b1) begin
      failures++; $display("FAIL halt_set got=%b exp=1", Halt);
    end
    @(negedge Clk);
    ALUop = 5'd0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    checks++;
    if (Halt !== 1'b1) begin
      failures++; $display("FAIL halt_sticky got=%b exp=1", Halt);
    end
    @(negedge Clk);
    Rst = 1'b1; ALUop = 5'h1F;
    @(posedge Clk); #1;
    checks++;
    if (Halt !== 1'b0) begin
      failures++; $display("FAIL halt_rst_priority got=%b exp=0", Halt);
    end
    @(negedge Clk);
    Rst = 1'b0; ALUop = 5'd0;
  endtask

  task automatic test_sub();
    set_op(5'd0, 6'h22, 1'b0, 32'd5, 32'd7);
    checks++;
    if (AluControl !== 3'b001 || AluResult !== 32'hFFFFFFFE || Zero !== 1'b0 || Positive !== 1'b0) begin
      failures++;
      $display("FAIL sub_neg got ctrl=%b res=%h z=%b p=%b exp ctrl=001 res=fffffffe z=0 p=0",
               AluControl, AluResult, Zero, Positive);
    end
    set_op(5'd0, 6'h22, 1'b0, 32'd9, 32'd9);
    checks++;
    if (AluResult !== 32'd0 || Zero !== 1'b1 || Positive !== 1'b0) begin
      failures++;
      $display("FAIL sub_zero got res=%h z=%b p=%b exp res=0 z=1 p=0", AluResult, Zero, Positive);
    end
  endtask

  task automatic test_branch_slt();
    set_op(5'd2, 6'h24, 1'b1, 32'd3, 32'd3);
    checks++;
    if (AluControl !== 3'b001 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL branch_sub got ctrl=%b z=%b exp ctrl=001 z=1", AluControl, Zero);
    end
    set_op(5'd0, 6'h2A, 1'b0, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (AluControl !== 3'b110 || AluResult !== 32'd1 || Positive !== 1'b1) begin
      failures++;
      $display("FAIL slt_true got ctrl=%b res=%h p=%b exp ctrl=110 res=1 p=1", AluControl, AluResult, Positive);
    end
    set_op(5'd0, 6'h2A, 1'b0, 32'd1, 32'hFFFFFFFF);
    checks++;
    if (AluResult !== 32'd0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL slt_false got res=%h z=%b exp res=0 z=1", AluResult, Zero);
    end
    set_op(5'd0, 6'h2B, 1'b0, 32'h80000000, 32'd0);
    checks++;
    if (AluControl !== 3'b110 || AluResult !== 32'd1) begin
      failures++;
      $display("FAIL sltu_signed got ctrl=%b res=%h exp ctrl=110 res=1", AluControl, AluResult);
    end
  endtask

  task automatic test_multdiv();
    ALUBusy = 1'b1;
    set_op(5'd0, 6'h18, 1'b0, 32'd0, 32'd0);
    checks++;
    if (AluFrontSel !== 1'b0 || MultiClk !== 1'b1) begin
      failures++;
      $display("FAIL mult_busy got sel=%b mc=%b exp sel=0 mc=1", AluFrontSel, MultiClk);
    end
    set_op(5'd0, 6'h1B, 1'b0, 32'd0, 32'd0);
    checks++;
    if (AluFrontSel !== 1'b0 || MultiClk !== 1'b1 || AluControl !== 3'b000) begin
      failures++;
      $display("FAIL divu_busy got sel=%b mc=%b ctrl=%b exp sel=0 mc=1 ctrl=000",
               AluFrontSel, MultiClk, AluControl);
    end
    ALUBusy = 1'b0; #1;
    checks++;
    if (MultiClk !== 1'b0 || AluFrontSel !== 1'b0) begin
      failures++;
      $display("FAIL mult_idle got mc=%b sel=%b exp mc=0 sel=0", MultiClk, AluFrontSel);
    end
    ALUBusy = 1'b1;
    set_op(5'd0, 6'h20, 1'b0, 32'd0, 32'd0);
    checks++;
    if (MultiClk !== 1'b0 || AluFrontSel !== 1'b1) begin
      failures++;
      $display("FAIL add_busy got mc=%b sel=%b exp mc=0 sel=1", MultiClk, AluFrontSel);
    end
    set_op(5'd1, 6'h18, 1'b0, 32'd0, 32'd0);
    checks++;
    if (MultiClk !== 1'b0 || AluFrontSel !== 1'b1) begin
      failures++;
      $display("FAIL itype_func18 got mc=%b sel=%b exp mc=0 sel=1", MultiClk, AluFrontSel);
    end
    ALUBusy = 1'b0;
  endtask

  task automatic test_arith();
    set_op(5'd0, 6'h20, 1'b0, 32'h7FFFFFFF, 32'd1);
    checks++;
    if (AluResult !== 32'h80000000 || Positive !== 1'b0 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL add_ovf got res=%h p=%b z=%b exp res=80000000 p=0 z=0", AluResult, Positive, Zero);
    end
    set_op(5'd0, 6'h27, 1'b0, 32'd0, 32'd0);
    checks++;
    if (AluControl !== 3'b101 || AluResult !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL nor got ctrl=%b res=%h exp ctrl=101 res=ffffffff", AluControl, AluResult);
    end
    set_op(5'd6, 6'h00, 1'b0, 32'h00000055, 32'h12340000);
    checks++;
    if (AluControl !== 3'b111 || AluResult !== 32'h12340000 || Positive !== 1'b1) begin
      failures++;
      $display("FAIL lui got ctrl=%b res=%h p=%b exp ctrl=111 res=12340000 p=1", AluControl, AluResult, Positive);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
  } vec_t;

  task automatic test_decode_table();
    vec_t v[9];
    v[0] = '{5'd2,  6'h00, 32'h0000FF0F, 32'h00000FF0, 3'b010, 32'h00000F00};
    v[1] = '{5'd3,  6'h00, 32'h0000F000, 32'h0000000F, 3'b011, 32'h0000F00F};
    v[2] = '{5'd4,  6'h00, 32'h0000FFFF, 32'h000000FF, 3'b100, 32'h0000FF00};
    v[3] = '{5'd5,  6'h00, 32'hFFFFFFF0, 32'h00000003, 3'b110, 32'h00000001};
    v[4] = '{5'd7,  6'h00, 32'h10000000, 32'h00000010, 3'b000, 32'h10000010};
    v[5] = '{5'd10, 6'h22, 32'd6,        32'd4,        3'b000, 32'd10};
    v[6] = '{5'd0,  6'h02, 32'hABCD0000, 32'd0,        3'b000, 32'hABCD0000};
    v[7] = '{5'd0,  6'h25, 32'h0F000000, 32'h000000F0, 3'b011, 32'h0F0000F0};
    v[8] = '{5'd0,  6'h26, 32'hFFFF0000, 32'hFF00FF00, 3'b100, 32'h00FFFF00};
    for (int i = 0; i < 9; i++) begin
      set_op(v[i].op, v[i].fn, 1'b0, v[i].a, v[i].b);
      checks++;
      if (AluControl !== v[i].ctrl || AluResult !== v[i].res) begin
        failures++;
        $display("FAIL decode_vec%0d got ctrl=%b res=%h exp ctrl=%b res=%h",
                 i, AluControl, AluResult, v[i].ctrl, v[i].res);
      end
    end
  endtask

  task automatic test_adder();
    AddA = 32'h00400000; AddB = 32'd4; #1;
    checks++;
    if (AddSum !== 32'h00400004) begin
      failures++; $display("FAIL adder_pc got=%h exp=00400004", AddSum);
    end
    AddA = 32'hFFFFFFFC; AddB = 32'd4; #1;
    checks++;
    if (AddSum !== 32'h00000000) begin
      failures++; $display("FAIL adder_wrap got=%h exp=00000000", AddSum);
    end
  endtask

  initial begin
    Rst = 1'b0; ALUop = 5'd0; Func = 6'd0; Branch = 1'b0; ALUBusy = 1'b0;
    AluIn1 = '0; AluIn2 = '0; AddA = '0; AddB = '0;
    test_reset();
    test_halt();
    test_sub();
    test_branch_slt();
    test_multdiv();
    test_arith();
    test_decode_table();
    test_adder();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
